// File: rtl/ask_demod.sv
// ask_demod: on-off-keyed ASK demodulator with symbol timing recovered from the first '1',
// threshold bit decisions, MSB-first byte assembly and lock tracking.
module ask_demod #(
   parameter int SYM_CLKS  = 16,
   parameter int THRESH    = SYM_CLKS / 4,
   parameter int IDLE_SYMS = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ask_in,
   output logic       bit_out,
   output logic       bit_valid,
   output logic [7:0] byte_out,
   output logic       byte_valid,
   output logic       locked
);
   localparam int SW = $clog2(SYM_CLKS);
   localparam int OW = $clog2(SYM_CLKS + 1);
   localparam int ZW = $clog2(IDLE_SYMS + 1);
   typedef enum logic {IDLE, RUN} state_t;
   state_t state, state_nx;
   logic [SW-1:0] sample_cnt;
   logic [OW-1:0] ones_cnt;
   logic [ZW-1:0] zero_cnt;
   logic [2:0] bit_idx;
   logic [7:0] shift;
   logic sym_end, decision, drop;
   assign sym_end  = state == RUN && sample_cnt == SW'(SYM_CLKS - 1);
   assign decision = (ones_cnt + OW'(ask_in)) >= OW'(THRESH);
   assign drop     = sym_end && !decision && zero_cnt == ZW'(IDLE_SYMS - 1);
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else state <= state_nx;
   end
   always_comb begin
      state_nx = state == IDLE ? (ask_in ? RUN : IDLE) : (drop ? IDLE : RUN);
   end
   always_comb begin
      locked = state == RUN;
   end
   // The locking sample is symbol position 0, so IDLE preloads both counters with ask_in.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sample_cnt <= '0;
         ones_cnt   <= '0;
         zero_cnt   <= '0;
         bit_idx    <= '0;
         shift      <= '0;
         bit_out    <= 1'b0;
         bit_valid  <= 1'b0;
         byte_out   <= '0;
         byte_valid <= 1'b0;
      end else begin
         bit_valid  <= sym_end;
         byte_valid <= sym_end && bit_idx == 3'd7;
         if (state == IDLE) begin
            sample_cnt <= SW'(ask_in);
            ones_cnt   <= OW'(ask_in);
         end else if (sym_end) begin
            sample_cnt <= '0;
            ones_cnt   <= '0;
            bit_out    <= decision;
            shift      <= {shift[6:0], decision};
            bit_idx    <= drop ? 3'd0 : bit_idx + 3'd1;
            zero_cnt   <= (decision || drop) ? '0 : zero_cnt + ZW'(1);
            if (bit_idx == 3'd7) byte_out <= {shift[6:0], decision};
         end else begin
            sample_cnt <= sample_cnt + SW'(1);
            ones_cnt   <= ones_cnt + OW'(ask_in);
         end
      end
   end
endmodule

// File: tb/tb_ask_demod.sv
// tb_ask_demod: randomized scoreboard bench; a window-based reference model predicts every
// bit/byte pulse with its exact cycle, and a monitor checks whatever the DUT presents.
module tb_ask_demod;
   localparam int SYM = 16, TH = 4, IDL = 4;
   logic clk = 1'b0, rst = 1'b0, ask_in = 1'b0;
   logic bit_out, bit_valid, byte_valid, locked;
   logic [7:0] byte_out;
   ask_demod #(.SYM_CLKS(SYM), .THRESH(TH), .IDLE_SYMS(IDL)) dut (
      .clk(clk), .rst(rst), .ask_in(ask_in), .bit_out(bit_out), .bit_valid(bit_valid),
      .byte_out(byte_out), .byte_valid(byte_valid), .locked(locked)
   );
   always #5 clk = ~clk;
   typedef struct {int e; bit b; bit hb; logic [7:0] v; bit lk;} exp_t;
   exp_t q[$];
   exp_t it;
   bit lk[int];
   int cyc = 0, total = 0, bad = 0;
   bit m_lock = 0;
   bit win[$];
   bit bits[$];
   int zr = 0;
   logic last_bit = 1'b0;
   logic [7:0] last_byte = 8'h00;
   always @(posedge clk) cyc++;
   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
      total++;
      if (a !== e) begin
         bad++;
         $display("FAIL %s at edge %0d: got %0h want %0h", n, cyc, a, e);
      end
   endtask
   // Reference: once a '1' is seen, group samples into windows of SYM and decide by ones count.
   task automatic model(input bit s, input int e);
      exp_t x;
      int ones;
      if (!m_lock) begin
         if (s) begin
            m_lock = 1;
            win = {s};
         end
      end else begin
         win.push_back(s);
         if (win.size() == SYM) begin
            ones = 0;
            foreach (win[i]) ones += int'(win[i]);
            x.e = e;
            x.b = ones >= TH;
            win.delete();
            bits.push_back(x.b);
            zr = x.b ? 0 : zr + 1;
            x.hb = bits.size() == 8;
            x.v = 8'h00;
            if (x.hb) begin
               foreach (bits[i]) x.v = {x.v[6:0], bits[i]};
               bits.delete();
            end
            if (zr == IDL) begin
               m_lock = 0;
               bits.delete();
               zr = 0;
            end
            x.lk = m_lock;
            q.push_back(x);
         end
      end
      lk[e] = m_lock;
   endtask
   task automatic drive(input bit s);
      @(negedge clk);
      ask_in = s;
      model(s, cyc + 1);
   endtask
   task automatic send_bit(input bit b);
      for (int k = 0; k < SYM; k++) drive(b && (k % 4 < 2));
   endtask
   task automatic do_reset();
      @(posedge clk);
      #2 rst = 1'b0;
      #1;
      chk("rst_bit_out", bit_out, 0);
      chk("rst_bit_valid", bit_valid, 0);
      chk("rst_byte_out", byte_out, 0);
      chk("rst_byte_valid", byte_valid, 0);
      chk("rst_locked", locked, 0);
      q.delete();
      lk.delete();
      win.delete();
      bits.delete();
      m_lock = 0;
      zr = 0;
      last_bit = 1'b0;
      last_byte = 8'h00;
      ask_in = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
   endtask
   always @(negedge clk) begin
      if (rst) begin
         while (q.size() > 0 && q[0].e < cyc) begin
            chk("missed_bit_valid", 0, 1);
            void'(q.pop_front());
         end
         if (bit_valid) begin
            if (q.size() == 0 || q[0].e != cyc) chk("spurious_bit_valid", 1, 0);
            else begin
               it = q.pop_front();
               chk("bit_value", bit_out, it.b);
               chk("byte_valid", byte_valid, it.hb);
               if (it.hb) chk("byte_value", byte_out, it.v);
               chk("locked_at_bit", locked, it.lk);
               last_bit = it.b;
               if (it.hb) last_byte = it.v;
            end
         end else if (byte_valid) chk("lone_byte_valid", 1, 0);
         chk("bit_out_hold", bit_out, last_bit);
         chk("byte_out_hold", byte_out, last_byte);
         if (lk.exists(cyc)) chk("locked", locked, lk[cyc]);
      end
   end
   initial begin
      bit d[8];
      int n;
      do_reset();
      repeat (200) drive(0);
      chk("idle_locked", locked, 0);
      d = '{1, 0, 1, 1, 0, 0, 1, 0};
      foreach (d[i]) send_bit(d[i]);
      drive(0);
      chk("byte_b2", byte_out, 8'hB2);
      repeat (100) drive(0);
      chk("dropped_after_b2", locked, 0);
      send_bit(1);
      repeat (4) drive(1);
      repeat (12) drive(0);
      drive(1);
      chk("thresh_4_ones", bit_out, 1);
      repeat (2) drive(1);
      repeat (13) drive(0);
      drive(0);
      chk("thresh_3_ones", bit_out, 0);
      repeat (100) drive(0);
      send_bit(1);
      repeat (90) drive(0);
      chk("zero_run_drop", locked, 0);
      send_bit(1);
      for (int i = 0; i < 7; i++) send_bit(1'($urandom_range(0, 1)));
      repeat (100) drive(0);
      for (int i = 0; i < 7; i++) send_bit(1);
      repeat (20) drive(0);
      chk("byte_fe", byte_out, 8'hFE);
      repeat (60) drive(0);
      chk("dropped_after_fe", locked, 0);
      send_bit(1);
      send_bit(0);
      repeat (7) drive(1);
      do_reset();
      repeat (40) drive(0);
      chk("post_reset_idle", locked, 0);
      for (int r = 0; r < 12; r++) begin
         n = $urandom_range(1, 12);
         send_bit(1);
         for (int i = 1; i < n; i++) send_bit(1'($urandom_range(0, 1)));
         repeat ($urandom_range(0, 90)) drive(0);
         if (r % 4 == 3) repeat (60) drive(1'($urandom_range(0, 1)));
         if (r == 6) begin
            send_bit(1);
            repeat (5) drive(1);
            do_reset();
         end
      end
      repeat (120) drive(0);
      chk("drain", q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
